// File: rtl/phy_pkg.sv
// Line-coding constants and receive-state encoding shared by both ends of the PHY serial link.
package phy_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int SYNC_COUNT = 4;

    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE  = 8'h7C;

    localparam int BIT_CNT_W = $clog2(BYTE_W);
    localparam int IDX_W     = $clog2(WORD_BYTES);
    localparam int CNT_W     = $clog2(SYNC_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    // Line characters that never carry payload.
    function automatic logic is_control(input logic [BYTE_W-1:0] b);
        return (b == COMMA) || (b == IDLE);
    endfunction

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Lane-side bundle of the RX deserializer: serial bit in, reassembled words and status out.
interface phy_rx_deserializer_if;
    import phy_pkg::*;

    // valid_out is a one-cycle strobe with no backpressure: data_out is meaningful
    // in the cycle valid_out is high and holds until the next word replaces it.
    logic              serial_in;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic              active;
    logic              err;
    rx_state_t         state;

    modport master (
        input  serial_in,
        output data_out,
        output valid_out,
        output active,
        output err,
        output state
    );

    modport slave (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  err,
        input  state
    );

endinterface

// File: rtl/phy_rx_byte_align.sv
// Serial-to-parallel shifter with a byte-phase counter; the byte and comma match are
// presented on the incoming bit so the owner can act on the edge that completes a byte.
module phy_rx_byte_align
    import phy_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              realign,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_stb,
    output logic              comma_hit
);

    logic [BYTE_W-1:0]    sr;
    logic [BIT_CNT_W-1:0] bit_cnt;

    assign byte_data = {sr[BYTE_W-2:0], serial_in};
    assign byte_stb  = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
    assign comma_hit = (byte_data == COMMA);

    // realign makes the comma just seen the byte boundary; the next byte completes 8 edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= byte_data;
            bit_cnt <= realign ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phy_rx_deserializer.sv
// Per-lane receiver: locks byte alignment on repeated commas, then packs data
// bytes into words, dropping IDLE/COMMA fillers and flagging torn words.
module phy_rx_deserializer
    import phy_pkg::*;
(
    input  logic                  clk_32f,
    input  logic                  reset,
    phy_rx_deserializer_if.master rx
);

    logic [BYTE_W-1:0] byte_data;
    logic              byte_stb;
    logic              comma_hit;
    logic              realign;

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  comma_cnt_q, comma_cnt_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_BYTES-1:0][BYTE_W-1:0] slots_q, slots_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    phy_rx_byte_align u_align (
        .clk       (clk_32f),
        .rst       (reset),
        .serial_in (rx.serial_in),
        .realign   (realign),
        .byte_data (byte_data),
        .byte_stb  (byte_stb),
        .comma_hit (comma_hit)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            comma_cnt_q <= '0;
            byte_idx_q  <= '0;
            slots_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            byte_idx_q  <= byte_idx_d;
            slots_q     <= slots_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        byte_idx_d  = byte_idx_q;
        slots_d     = slots_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        realign     = 1'b0;

        case (state_q)
            HUNT: begin
                if (comma_hit) begin
                    realign     = 1'b1;
                    comma_cnt_d = CNT_W'(1);
                    state_d     = (SYNC_COUNT == 1) ? ACTIVE : SYNC;
                end
            end

            // Only commas landing on the current boundary count toward lock.
            SYNC: begin
                if (byte_stb) begin
                    if (byte_data == COMMA) begin
                        comma_cnt_d = comma_cnt_q + 1'b1;
                        if (comma_cnt_q == CNT_W'(SYNC_COUNT - 1)) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
            end

            ACTIVE: begin
                if (byte_stb) begin
                    if (is_control(byte_data)) begin
                        err_d      = (byte_idx_q != '0);
                        byte_idx_d = '0;
                    end else begin
                        // Slot 0 of the lane lands in the top byte of the word.
                        slots_d[IDX_W'(WORD_BYTES - 1) - byte_idx_q] = byte_data;
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == IDX_W'(WORD_BYTES - 1)) begin
                            data_d     = slots_d;
                            valid_d    = 1'b1;
                            byte_idx_d = '0;
                        end
                    end
                end
            end

            default: state_d = HUNT;
        endcase
    end

    assign rx.data_out  = data_q;
    assign rx.valid_out = valid_q;
    assign rx.err       = err_q;
    assign rx.active    = (state_q == ACTIVE);
    assign rx.state     = state_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed and random serial streams against a bit-position model of comma lock and word packing.
module tb_phy_rx_deserializer;
    import phy_pkg::*;

    logic clk_32f = 1'b0;
    logic reset;

    phy_rx_deserializer_if rx_if ();

    phy_rx_deserializer dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .rx      (rx_if.master)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_32f = ~clk_32f;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    bit          bits[$];
    int          obs_idx[$];
    logic [31:0] obs_word[$];
    int          obs_err[$];
    int          obs_act;
    logic [31:0] exp_q[$];
    int          exp_idx[$];
    int          exp_err[$];
    int          exp_act;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_bit(input bit b);
        rx_if.serial_in = b;
        bits.push_back(b);
        @(posedge clk_32f);
        #1;
        if (rx_if.valid_out === 1'b1) begin
            obs_idx.push_back(bits.size() - 1);
            obs_word.push_back(rx_if.data_out);
        end
        if (rx_if.err === 1'b1) obs_err.push_back(bits.size() - 1);
        if (rx_if.active === 1'b1 && obs_act < 0) obs_act = bits.size() - 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_data"},   rx_if.data_out, 32'h0);
        chk({tag, "_valid"},  32'(rx_if.valid_out), 32'h0);
        chk({tag, "_active"}, 32'(rx_if.active), 32'h0);
        chk({tag, "_err"},    32'(rx_if.err), 32'h0);
        chk({tag, "_state"},  32'(rx_if.state), 32'(HUNT));
        bits.delete();
        obs_idx.delete();
        obs_word.delete();
        obs_err.delete();
        obs_act = -1;
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Character ending at bit position n, MSB first; positions before reset read as 0.
    function automatic logic [7:0] win(input int n);
        logic [7:0] v = '0;
        for (int k = n - 7; k <= n; k++) v = {v[6:0], (k >= 0) ? logic'(bits[k]) : 1'b0};
        return v;
    endfunction

    task automatic run_model();
        int          nbits = bits.size();
        int          n = 0;
        int          pos;
        int          cnt;
        int          slot;
        logic [7:0]  b;
        logic [31:0] w;
        exp_q.delete();
        exp_idx.delete();
        exp_err.delete();
        exp_act = -1;
        while (n < nbits && exp_act < 0) begin
            if (win(n) != COMMA) begin
                n++;
            end else begin
                pos = n;
                cnt = 1;
                while (cnt < SYNC_COUNT && pos + 8 < nbits && win(pos + 8) == COMMA) begin
                    pos += 8;
                    cnt++;
                end
                if (cnt == SYNC_COUNT) exp_act = pos;
                else if (pos + 8 < nbits) n = pos + 9;
                else n = nbits;
            end
        end
        if (exp_act >= 0) begin
            slot = 0;
            w    = '0;
            for (int p = exp_act + 8; p < nbits; p += 8) begin
                b = win(p);
                if (b == COMMA || b == IDLE) begin
                    if (slot != 0) exp_err.push_back(p);
                    slot = 0;
                end else begin
                    w = {w[23:0], b};
                    slot++;
                    if (slot == 4) begin
                        exp_idx.push_back(p);
                        exp_q.push_back(w);
                        slot = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_segment(input string tag);
        run_model();
        chk({tag, "_act_idx"}, 32'(obs_act), 32'(exp_act));
        chk({tag, "_nwords"}, 32'(obs_idx.size()), 32'(exp_idx.size()));
        for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
            chk($sformatf("%s_word%0d_idx", tag, i), 32'(obs_idx[i]), 32'(exp_idx[i]));
            chk($sformatf("%s_word%0d", tag, i), obs_word[i], exp_q[i]);
        end
        chk({tag, "_nerr"}, 32'(obs_err.size()), 32'(exp_err.size()));
        for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++)
            chk($sformatf("%s_err%0d_idx", tag, i), 32'(obs_err[i]), 32'(exp_err[i]));
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] word_bytes[] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEE, 8'hEE, 8'hEE, 8'hEE,
                                 8'h00, 8'h00, 8'h00, 8'h03, 8'h7C, 8'h7C,
                                 8'h00, 8'h00, 8'h00, 8'h04,
                                 8'hAA, 8'h99, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [31:0] word_exp[] = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'h00000003,
                                32'h00000004, 32'h01020304};

    initial begin
        logic [7:0] rb;
        int         kind;
        reset           = 1'b1;
        rx_if.serial_in = 1'b0;
        obs_act         = -1;
        do_reset("por");

        // Lock after a short random preamble.
        send_rand_bits(3);
        repeat (4) send_byte(COMMA);
        chk("lock_active", 32'(rx_if.active), 32'h1);
        chk("lock_at_bit", 32'(obs_act), 32'd34);
        check_segment("lock");

        // Three commas then data: no lock, back to hunting.
        do_reset("r_nolock");
        repeat (3) send_byte(COMMA);
        send_byte(8'h55);
        chk("nolock_active", 32'(rx_if.active), 32'h0);
        chk("nolock_state", 32'(rx_if.state), 32'(HUNT));
        check_segment("nolock");

        // Word packing, IDLE skipping and torn-word error.
        do_reset("r_words");
        send_rand_bits(3);
        repeat (4) send_byte(COMMA);
        foreach (word_bytes[i]) send_byte(word_bytes[i]);
        check_segment("words");
        chk("words_count", 32'(obs_word.size()), 32'd5);
        foreach (word_exp[i]) chk($sformatf("words_direct%0d", i), obs_word[i], word_exp[i]);
        chk("words_ff_ee_gap", 32'(obs_idx[1] - obs_idx[0]), 32'd32);
        chk("words_err_count", 32'(obs_err.size()), 32'd1);
        chk("words_hold", rx_if.data_out, 32'h01020304);

        // Reset in the middle of a word.
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset("r_mid");
        repeat (3) send_byte(COMMA);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk("mid_short_active", 32'(rx_if.active), 32'h0);
        chk("mid_short_words", 32'(obs_word.size()), 32'd0);
        check_segment("mid_short");
        repeat (4) send_byte(COMMA);
        send_byte(8'h9A); send_byte(8'h5B); send_byte(8'h6C); send_byte(8'h7D);
        chk("mid_relock_words", 32'(obs_word.size()), 32'd1);
        chk("mid_relock_word", obs_word[0], 32'h9A5B6C7D);
        check_segment("mid_relock");

        // Random payload with random IDLE / comma insertions.
        do_reset("r_rand");
        send_rand_bits(5);
        repeat (4) send_byte(COMMA);
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_byte(IDLE);
            end else if (kind == 1) begin
                send_byte(COMMA);
            end else begin
                do rb = 8'($urandom_range(0, 255)); while (rb == COMMA || rb == IDLE);
                send_byte(rb);
            end
        end
        check_segment("rand");
        if (exp_q.size() > 0) chk("rand_hold", rx_if.data_out, exp_q[exp_q.size() - 1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
